// File: rtl/mips_multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl_if
// Bundle of the signals that pass between the multicycle MIPS control unit
// and its datapath.
//   Op, Funct, Zero       : instruction fields from IR and the ALU zero flag
//   IorD .. PCEn          : datapath selects and write enables
//   State                 : current controller state, for observation
// Modports:
//   master : the control unit (consumes Op/Funct/Zero, drives the controls)
//   slave  : the datapath side (drives Op/Funct/Zero, consumes the controls)
// ---------------------------------------------------------------------------
interface mips_multicycle_ctrl_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic [3:0] State;

    modport master (
        input  Op, Funct, Zero,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, State
    );

    modport slave (
        output Op, Funct, Zero,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, State
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
// Moore control unit for the multicycle MIPS datapath. Sequences each
// instruction through fetch / decode / execute / memory / writeback and
// drives every datapath select and enable.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; state returns to FETCH and the
//            write enables (PCEn, IRWrite, RegWrite, MemWrite) are held low
//            for as long as it is asserted
//   bus    : mips_multicycle_ctrl_if.master (Op, Funct, Zero in; controls
//            and State out)
// Build option:
//   MULTICYCLE_BNE_EN : adds bne (Op 000101) via a branch-sense register
//                       captured in DECODE.
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl (
    input  logic                          clk,
    input  logic                          reset,
    mips_multicycle_ctrl_if.master        bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
    } ctl_t;

    // Control word for a given state. Funct only matters in EXECUTE; it is
    // stable from DECODE onward, so decoding it one cycle early is safe.
    function automatic ctl_t decode_ctl(input state_t s, input logic [5:0] funct);
        ctl_t c;
        c             = '0;
        c.alu_control = 3'b010;
        case (s)
            FETCH: begin
                c.alu_src_b = 2'b01;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
            end
            DECODE:   c.alu_src_b = 2'b11;
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD:    c.iord = 1'b1;
            MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b00;
                case (funct)
                    6'b100000: c.alu_control = 3'b010;
                    6'b100010: c.alu_control = 3'b110;
                    6'b100100: c.alu_control = 3'b000;
                    6'b100101: c.alu_control = 3'b001;
                    6'b101010: c.alu_control = 3'b111;
                    default:   c.alu_control = 3'b010;
                endcase
            end
            ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = 2'b00;
                c.alu_control = 3'b110;
                c.pc_src      = 2'b01;
                c.branch      = 1'b1;
            end
            ADDIEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ADDIWB:   c.reg_write = 1'b1;
            JUMP: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    state_t state_q, state_d;
    ctl_t   ctl_q, ctl_d;
`ifdef MULTICYCLE_BNE_EN
    logic   is_bne_q, is_bne_d;
`endif

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
`ifdef MULTICYCLE_BNE_EN
                    OP_BNE:       state_d = BRANCH;
`endif
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;   // unknown Op acts as a NOP
                endcase
            end
            MEMADR:   state_d = (bus.Op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    state_d = MEMWB;
            EXECUTE:  state_d = ALUWB;
            ADDIEXEC: state_d = ADDIWB;
            default:  state_d = FETCH;   // writeback/terminal states and codes 12-15
        endcase
        // Outputs are registered alongside the state, so they are decoded
        // from the state being entered.
        ctl_d = decode_ctl(state_d, bus.Funct);
    end

`ifdef MULTICYCLE_BNE_EN
    // Branch sense captured while Op is decoded; held through BRANCH.
    always_comb begin
        is_bne_d = is_bne_q;
        if (state_q == DECODE) begin
            is_bne_d = (bus.Op == OP_BNE);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ctl_q   <= decode_ctl(FETCH, bus.Funct);
`ifdef MULTICYCLE_BNE_EN
            is_bne_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
`ifdef MULTICYCLE_BNE_EN
            is_bne_q <= is_bne_d;
`endif
        end
    end

    // Write enables are gated by reset directly so an instruction aborted
    // by reset cannot write anything in the cycle reset is raised.
    assign bus.IorD       = ctl_q.iord;
    assign bus.MemWrite   = ctl_q.mem_write & ~reset;
    assign bus.IRWrite    = ctl_q.ir_write & ~reset;
    assign bus.RegDst     = ctl_q.reg_dst;
    assign bus.MemtoReg   = ctl_q.mem_to_reg;
    assign bus.RegWrite   = ctl_q.reg_write & ~reset;
    assign bus.ALUSrcA    = ctl_q.alu_src_a;
    assign bus.ALUSrcB    = ctl_q.alu_src_b;
    assign bus.ALUControl = ctl_q.alu_control;
    assign bus.PCSrc      = ctl_q.pc_src;
    assign bus.State      = state_q;
`ifdef MULTICYCLE_BNE_EN
    assign bus.PCEn = ~reset & (ctl_q.pc_write | (ctl_q.branch & (bus.Zero ^ is_bne_q)));
`else
    assign bus.PCEn = ~reset & (ctl_q.pc_write | (ctl_q.branch & bus.Zero));
`endif

endmodule
